// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg: shared types and constants for the seven-segment scan driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g}; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic [2:0] msd_index(input logic [31:0] w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w[4*i +: 4] != 4'h0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode: combinational hex nibble to active-low segment pattern.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver: registered multiplexed 8-digit hex display scanner with
// valid/ready capture, frame-boundary data swap and inter-digit blanking.
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the top nonzero one.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int DIGIT_CYCLES = 32768,
  parameter int GAP_CYCLES   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [31:0]       data,
  output logic              data_ready,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int c_DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_CWD  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int c_CWG  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_CW   = (c_CWD > c_CWG) ? c_CWD : c_CWG;
  localparam bit c_HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [c_CW-1:0] c_DRIVE_LAST = c_CW'(DIGIT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_DW-1:0] c_DIG_LAST   = c_DW'(DIGITS - 1);

  scan_state_t       state_q, state_d;
  logic [c_DW-1:0]   digit_q, digit_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       pending_q, pending_d;
  logic              pend_q, pend_d;
  logic              swap_q, swap_d;
  logic              wrap_q, wrap_d;
  logic              ready_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              frame_done_q;

  logic              w_accept;
  logic              w_adv;
  logic              w_show;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;

  assign w_accept = data_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    swap_d    = 1'b0;
    wrap_d    = 1'b0;
    w_adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          shadow_d = data;
          state_d  = DRIVE;
          digit_d  = '0;
          cnt_d    = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == c_DRIVE_LAST) begin
          cnt_d = '0;
          if (c_HAS_GAP) state_d = GAP;
          else           w_adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
          w_adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The swap is decided from the pending flag before this edge's accept,
    // so a word captured on the wrap edge waits for the following frame.
    if (w_adv) begin
      if (digit_q == c_DIG_LAST) begin
        digit_d = '0;
        wrap_d  = 1'b1;
        swap_d  = pend_q && !swap_q;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end

    if (swap_q) begin
      shadow_d = pending_q;
      pend_d   = 1'b0;
    end

    if (w_accept && (state_q != IDLE)) begin
      pending_d = data;
      pend_d    = 1'b1;
    end
  end

  // Decode from next shadow so digit 0 of a swapped frame already shows new data.
  assign w_nib = shadow_d[{digit_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib_i (w_nib),
    .seg_o (w_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_show = (state_q == DRIVE) && (int'(digit_q) <= int'(msd_index(shadow_d)));
`else
  assign w_show = (state_q == DRIVE);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      digit_q      <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      swap_q       <= 1'b0;
      wrap_q       <= 1'b0;
      ready_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      swap_q       <= swap_d;
      wrap_q       <= wrap_d;
      ready_q      <= ~pend_d;
      an_q         <= w_show ? ~(DIGITS'(1) << digit_q) : '1;
      seg_q        <= w_show ? w_seg : SEG_BLANK;
      frame_done_q <= wrap_q;
    end
  end

  assign data_ready = ready_q;
  assign segments   = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with DIGITS=8,
// DIGIT_CYCLES=4, GAP_CYCLES=1 (40-cycle frame).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready;
  logic [6:0]  segments;
  logic [7:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [6:0] tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan_driver #(
    .DIGITS       (8),
    .DIGIT_CYCLES (4),
    .GAP_CYCLES   (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .segments   (segments),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int top_digit(input logic [31:0] w);
    int m;
    m = 0;
    for (int i = 0; i < 8; i++) if (w[4*i +: 4] != 4'h0) m = i;
    return m;
  endfunction

  // One frame (or its first ncyc cycles) of expected output for word `shown`.
  task automatic run_frame(input logic [31:0] shown, input logic fd0, input int send_at,
                           input logic [31:0] send_word, input logic rdy0, input int ncyc);
    int d;
    int p;
    logic on;
    logic [3:0] nib;
    for (int t = 0; t < ncyc; t++) begin
      tick();
      d  = t / 5;
      p  = t % 5;
      on = (p < 4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d > top_digit(shown)) on = 1'b0;
`endif
      nib = shown[4*d +: 4];
      chk("an", {24'h0, an}, on ? {24'h0, ~(8'h01 << d)} : 32'hFF);
      chk("segments", {25'h0, segments}, on ? {25'h0, tab[nib]} : 32'h7F);
      chk("frame_done", {31'h0, frame_done}, (t == 0) ? {31'h0, fd0} : 32'h0);
      chk("data_ready", {31'h0, data_ready},
          (send_at >= 0 && t > send_at) ? 32'h0 : {31'h0, rdy0});
      if (t == send_at) begin
        data_valid = 1'b1;
        data       = send_word;
      end else begin
        data_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_accept(input logic [31:0] w);
    data_valid = 1'b1;
    data       = w;
    tick();
    chk("accept_blank_an", {24'h0, an}, 32'hFF);
    chk("accept_ready", {31'h0, data_ready}, 32'h1);
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data       = 32'h0;
    repeat (3) tick();
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {25'h0, segments}, 32'h7F);
    chk("rst_ready", {31'h0, data_ready}, 32'h0);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);

    reset = 1'b0;
    tick();
    chk("post_rst_ready", {31'h0, data_ready}, 32'h1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_an", {24'h0, an}, 32'hFF);
      chk("idle_seg", {25'h0, segments}, 32'h7F);
      chk("idle_fd", {31'h0, frame_done}, 32'h0);
      chk("idle_ready", {31'h0, data_ready}, 32'h1);
    end

    idle_accept(32'h0000_2FFF);
    run_frame(32'h0000_2FFF, 1'b0, -1, 32'h0, 1'b1, 40);
    run_frame(32'h0000_2FFF, 1'b1, 10, 32'hDEAD_BEEF, 1'b1, 40);
    run_frame(32'hDEAD_BEEF, 1'b1, 20, 32'h1234_5678, 1'b1, 40);
    // Word offered so that it is accepted on the frame-wrap edge.
    run_frame(32'h1234_5678, 1'b1, 38, 32'hCAFE_F00D, 1'b1, 40);
    run_frame(32'h1234_5678, 1'b1, -1, 32'h0, 1'b0, 40);
    run_frame(32'hCAFE_F00D, 1'b1, -1, 32'h0, 1'b1, 26);

    reset = 1'b1;
    tick();
    chk("midrst_an", {24'h0, an}, 32'hFF);
    chk("midrst_seg", {25'h0, segments}, 32'h7F);
    chk("midrst_ready", {31'h0, data_ready}, 32'h0);
    chk("midrst_fd", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;
    tick();
    chk("midrst_post_ready", {31'h0, data_ready}, 32'h1);
    chk("midrst_post_an", {24'h0, an}, 32'hFF);

    idle_accept(32'h0000_00A0);
    run_frame(32'h0000_00A0, 1'b0, 5, 32'h0, 1'b1, 40);
    run_frame(32'h0000_0000, 1'b1, -1, 32'h0, 1'b1, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Registered, time-multiplexed driver for the 8-digit common-anode seven-segment display.
- Consumes the 32-bit word produced by the PMP datapath (register read-back or check result) and renders it as 8 hex digits.
- Adds a valid/ready capture handshake with tear-free frame-boundary updates, an inter-digit blanking gap against ghosting, and a frame-done strobe.
- Sits directly downstream of the PMP register/check stage on the FPGA top level and replaces the free-running ripple-divider scan logic.

Parameters:
- DIGITS, 8, number of digits scanned; 1..8.
- DIGIT_CYCLES, 32768, clock cycles each digit is driven; >=1.
- GAP_CYCLES, 16, all-anodes-off cycles after each digit; 0 means no gap.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- data_valid, input, 1, upstream word available.
- data, input, 32, hex word; nibble k shown on digit k.
- data_ready, output, 1, driver can accept a word.
- segments, output, 7, active-low cathodes; bit6=a … bit0=g.
- an, output, DIGITS, active-low anodes; an[k] selects digit k.
- frame_done, output, 1, one-cycle pulse at end of each full scan frame.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Reset: sampled only on the clock edge. All state clears (shadow, pending, counters, state=IDLE).
  - While in reset: an = all ones, segments = 7'b1111111, data_ready = 0, frame_done = 0.
  - data_ready = 1 on the first cycle after reset deasserts.
  - Reset mid-frame aborts the scan immediately and pending data is lost.
- Handshake: a word is accepted when data_valid && data_ready at a clock edge. data is captured into the pending register and pend_flag is set. data_ready = !pend_flag (registered).
- States: IDLE, DRIVE, GAP.
- IDLE: display blank.
  - On accept, the word goes straight to the shadow (pend_flag not set).
  - Next state is DRIVE, digit=0, cnt=0.
- DRIVE: an = ~(1<<digit); segments = decode(shadow[4*digit+3:4*digit]). cnt counts 0..DIGIT_CYCLES-1.
  - At DIGIT_CYCLES-1: go to GAP with cnt=0 if GAP_CYCLES>0, otherwise advance the digit and stay in DRIVE.
- GAP: an = all ones, segments = 7'b1111111. At GAP_CYCLES-1: advance the digit, go to DRIVE.
- Digit advance: digit wraps from DIGITS-1 to 0. On that wrap:
  - frame_done pulses for exactly one cycle, coincident with the first output cycle of digit 0.
  - If pend_flag is set, shadow <= pending and pend_flag clears, so data_ready rises on that same cycle.
- Data is never swapped mid-frame.
- Simultaneous accept and frame wrap on the same edge: the word just accepted is not transferred in that wrap. It waits for the next wrap.
- Frame period: DIGITS*(DIGIT_CYCLES+GAP_CYCLES) cycles.
- Outputs are fully registered: digit k appears one cycle after the state/counter update selecting it.
- Decode table (hex→segments):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Counter widths come from $clog2 of the respective parameter, minimum 1 bit. No driver state returns to IDLE except via reset.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- When defined: at each shadow load, the index of the most significant nonzero nibble is computed and registered as msd (0 if the word is 0). During DRIVE of any digit > msd, an stays all ones and segments = 7'b1111111. Timing is unchanged. Digit 0 is always shown.
- When undefined: every digit 0..DIGITS-1 is shown, including leading zeros.

Decomposition:
- seg7_pkg holds:
  - state enum scan_state_t {IDLE, DRIVE, GAP};
  - SEG_BLANK = 7'b1111111;
  - the 16-entry hex-to-segment constant table.
- One sub-module: seg7_decode (4-bit nibble in, 7-bit active-low segments out, combinational, uses the package table). It is instantiated once on the selected nibble.

Test Plan (DIGITS=8, DIGIT_CYCLES=4, GAP_CYCLES=1 unless stated):
- Reset then idle, no valid → an=8'hFF, segments=7'h7F for 100 cycles; data_ready=1 from first post-reset cycle; frame_done never pulses.
- Send data=32'h0000_2FFF → digit0 shows F (0111000) for 4 cycles, 1-cycle gap, digit1 F, digit2 F, digit3 '2' (0010010); frame_done pulses every 40 cycles.
- Mid-frame send 32'h1234_5678 while showing 32'hDEAD_BEEF → data_ready drops next cycle; rest of frame still shows DEADBEEF; new digits from next frame_done; data_ready returns high on that same cycle.
- Assert valid on the exact edge of frame wrap → word held pending; appears one frame later; no mixed-digit frame ever observed.
- Reset asserted mid-DRIVE of digit 5 → next cycle an=FF, segments blank, state IDLE; shadow is zero, and a new accept restarts at digit 0.
- With SEG7_LEADING_ZERO_BLANK_EN, data=32'h0000_00A0 → digits 0,1 shown (0,A); digits 2..7 anodes stay high; data=0 → only digit 0 shows '0'.
